// File: rtl/alu_pipe.sv
// alu_pipe: single-request ALU with a ready/valid handshake on each side.
// Most opcodes finish in one clock. Multiply (shift-add) and divide
// (restoring) take WIDTH iterations, one bit per clock.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   in_valid   request present on ctrl/x/y
//   in_ready   block is idle and can accept a request
//   ctrl       4-bit opcode
//   x, y       operands A and B, WIDTH bits
//   out_valid  result is held on out/carry/zero
//   out_ready  consumer takes the result this clock
//   out        registered result
//   carry      registered carry/borrow/overflow flag
//   zero       registered flag, 1 when out == 0
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;
  localparam logic [3:0] OP_ASR = 4'b1001;
  localparam logic [3:0] OP_ROL = 4'b1010;
  localparam logic [3:0] OP_ROR = 4'b1011;
  localparam logic [3:0] OP_CMP = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1101;
  localparam logic [3:0] OP_DIV = 4'b1110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   a_reg;    // captured x (multiplicand)
  logic [WIDTH-1:0]   b_reg;    // captured y (divisor)
  logic [3:0]         op_reg;
  logic [SW-1:0]      cnt;      // iteration index 0..WIDTH-1
  logic [2*WIDTH-1:0] p;        // {hi, lo}: mul {partial, multiplier}, div {remainder, quotient}

  logic             accept;
  logic             go_calc;
  logic             last_iter;
  logic [WIDTH:0]   sc_res;     // {carry, out} of a single-cycle opcode
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [2*WIDTH-1:0] p_next;

  assign accept    = in_valid && in_ready;
  assign go_calc   = (ctrl == OP_MUL) || ((ctrl == OP_DIV) && (y != '0));
  assign last_iter = (cnt == SW'(WIDTH - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  // NOTE: every combinational output is given a default first so no path
  // through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = go_calc ? CALC : DONE;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs; in_ready is masked by rst so nothing is taken on a
  // reset edge.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // Single-cycle results straight from the ports (used on the accept edge).
  always_comb begin
    sc_res = '0;
    case (ctrl)
      OP_ADD: sc_res = {1'b0, x} + {1'b0, y};
      OP_SUB: sc_res = {1'b0, x} - {1'b0, y};  // top bit is the borrow
      OP_AND: sc_res = {1'b0, x & y};
      OP_OR:  sc_res = {1'b0, x | y};
      OP_NOT: sc_res = {1'b0, ~x};
      OP_XOR: sc_res = {1'b0, x ^ y};
      OP_NOR: sc_res = {1'b0, ~(x | y)};
      OP_SHL: sc_res = {1'b0, y << x[SW-1:0]};
      OP_SHR: sc_res = {1'b0, y >> x[SW-1:0]};
      OP_ASR: sc_res = {1'b0, x[WIDTH-1], x[WIDTH-1:1]};
      OP_ROL: sc_res = {1'b0, x[WIDTH-2:0], x[WIDTH-1]};
      OP_ROR: sc_res = {1'b0, x[0], x[WIDTH-1:1]};
      OP_CMP: sc_res = {{WIDTH{1'b0}}, (x == y)};
      OP_DIV: sc_res = {1'b1, {WIDTH{1'b1}}};  // only reached for y == 0
      default: sc_res = '0;
    endcase
  end

  // One multiply or divide iteration on the shared {hi, lo} register.
  always_comb begin
    mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
    div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_reg};
    if (op_reg == OP_MUL)
      p_next = {mul_sum, p[WIDTH-1:1]};
    else if (!div_trial[WIDTH])  // no wrap: shifted remainder >= divisor
      p_next = {div_trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    else
      p_next = {div_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= '0;
      cnt    <= '0;
      p      <= '0;
      out    <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_reg  <= x;
          b_reg  <= y;
          op_reg <= ctrl;
          cnt    <= '0;
          if (go_calc) begin
            p <= (ctrl == OP_MUL) ? {{WIDTH{1'b0}}, y} : {{WIDTH{1'b0}}, x};
          end else begin
            out   <= sc_res[WIDTH-1:0];
            carry <= sc_res[WIDTH];
            zero  <= (sc_res[WIDTH-1:0] == '0);
          end
        end
        CALC: begin
          p   <= p_next;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            out   <= p_next[WIDTH-1:0];
            carry <= (op_reg == OP_MUL) ? |p_next[2*WIDTH-1:WIDTH] : 1'b0;
            zero  <= (p_next[WIDTH-1:0] == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=8: a vector table covering every
// opcode plus hand-written reset, backpressure and mid-calculation reset
// sequences.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] ctrl;
  logic [7:0] x;
  logic [7:0] y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       carry;
  logic       zero;

  int total = 0;
  int bad   = 0;

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl      (ctrl),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry     (carry),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] c;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eo;
    logic       ec;
    int         el;
  } vec_t;

  vec_t vecs[27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one request with out_ready=1, measure the edges until out_valid
  // and check the result, then check the return to IDLE.
  task automatic run_op(input vec_t v);
    int lat;
    @(negedge clk);
    check({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
    ctrl      = v.c;
    x         = v.a;
    y         = v.b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0;
        x        = ~v.a;
        y        = ~v.b;
        ctrl     = ~v.c;
      end
    end while (!out_valid && lat < 40);
    check({v.name, "_latency"}, 32'(lat), 32'(v.el));
    check({v.name, "_out"},     32'(out),   32'(v.eo));
    check({v.name, "_carry"},   32'(carry), 32'(v.ec));
    check({v.name, "_zero"},    32'(zero),  32'(v.eo == 8'h00));
    @(posedge clk);
    #1;
    check({v.name, "_idle"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{"add_ff_01",  4'b0000, 8'hFF, 8'h01, 8'h00, 1'b1, 1};
    vecs[1]  = '{"add_7f_01",  4'b0000, 8'h7F, 8'h01, 8'h80, 1'b0, 1};
    vecs[2]  = '{"sub_05_07",  4'b0001, 8'h05, 8'h07, 8'hFE, 1'b1, 1};
    vecs[3]  = '{"sub_07_05",  4'b0001, 8'h07, 8'h05, 8'h02, 1'b0, 1};
    vecs[4]  = '{"and",        4'b0010, 8'hA5, 8'h3C, 8'h24, 1'b0, 1};
    vecs[5]  = '{"or",         4'b0011, 8'hA5, 8'h3C, 8'hBD, 1'b0, 1};
    vecs[6]  = '{"not",        4'b0100, 8'hA5, 8'h3C, 8'h5A, 1'b0, 1};
    vecs[7]  = '{"xor",        4'b0101, 8'hA5, 8'h3C, 8'h99, 1'b0, 1};
    vecs[8]  = '{"nor",        4'b0110, 8'hA5, 8'h3C, 8'h42, 1'b0, 1};
    vecs[9]  = '{"shl_3",      4'b0111, 8'h03, 8'h11, 8'h88, 1'b0, 1};
    vecs[10] = '{"shl_lowbits",4'b0111, 8'h0B, 8'h81, 8'h08, 1'b0, 1};
    vecs[11] = '{"shr_4",      4'b1000, 8'h04, 8'hF0, 8'h0F, 1'b0, 1};
    vecs[12] = '{"shr_7",      4'b1000, 8'h07, 8'h80, 8'h01, 1'b0, 1};
    vecs[13] = '{"asr_neg",    4'b1001, 8'h81, 8'h00, 8'hC0, 1'b0, 1};
    vecs[14] = '{"asr_pos",    4'b1001, 8'h7E, 8'h00, 8'h3F, 1'b0, 1};
    vecs[15] = '{"rol",        4'b1010, 8'h81, 8'h00, 8'h03, 1'b0, 1};
    vecs[16] = '{"ror",        4'b1011, 8'h81, 8'h00, 8'hC0, 1'b0, 1};
    vecs[17] = '{"cmp_eq",     4'b1100, 8'h3C, 8'h3C, 8'h01, 1'b0, 1};
    vecs[18] = '{"cmp_ne",     4'b1100, 8'h3C, 8'h3D, 8'h00, 1'b0, 1};
    vecs[19] = '{"reserved",   4'b1111, 8'hFF, 8'hFF, 8'h00, 1'b0, 1};
    vecs[20] = '{"mul_10_20",  4'b1101, 8'h10, 8'h20, 8'h00, 1'b1, 9};
    vecs[21] = '{"mul_0f_0f",  4'b1101, 8'h0F, 8'h0F, 8'hE1, 1'b0, 9};
    vecs[22] = '{"mul_ff_ff",  4'b1101, 8'hFF, 8'hFF, 8'h01, 1'b1, 9};
    vecs[23] = '{"div_64_07",  4'b1110, 8'h64, 8'h07, 8'h0E, 1'b0, 9};
    vecs[24] = '{"div_55_00",  4'b1110, 8'h55, 8'h00, 8'hFF, 1'b1, 1};
    vecs[25] = '{"div_ff_01",  4'b1110, 8'hFF, 8'h01, 8'hFF, 1'b0, 9};
    vecs[26] = '{"div_05_07",  4'b1110, 8'h05, 8'h07, 8'h00, 1'b0, 9};

    // Reset with a request pending: it must not be taken.
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    ctrl      = 4'b0000;
    x         = 8'hFF;
    y         = 8'h01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_in_ready_high", 32'(in_ready),  32'd1);
    check("rst_out_valid",     32'(out_valid), 32'd0);
    check("rst_out",           32'(out),       32'd0);
    check("rst_carry",         32'(carry),     32'd0);
    check("rst_zero",          32'(zero),      32'd0);
    @(posedge clk);
    #1;
    check("rst_no_accept_valid", 32'(out_valid), 32'd0);
    check("rst_no_accept_ready", 32'(in_ready),  32'd1);

    foreach (vecs[i]) run_op(vecs[i]);

    // Backpressure: result held while new requests are offered.
    @(negedge clk);
    out_ready = 1'b0;
    ctrl      = 4'b0000;
    x         = 8'h12;
    y         = 8'h34;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    x = 8'hFF;
    y = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid",    32'(out_valid), 32'd1);
      check("bp_out",      32'(out),       32'h46);
      check("bp_carry",    32'(carry),     32'd0);
      check("bp_zero",     32'(zero),      32'd0);
      check("bp_in_ready", 32'(in_ready),  32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready),  32'd1);
    check("bp_release_out",   32'(out),       32'h46);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_out",   32'(out),       32'hFE);
    check("bp_next_carry", 32'(carry),     32'd1);
    @(posedge clk);
    #1;
    check("bp_next_idle", 32'(out_valid), 32'd0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    ctrl     = 4'b1101;
    x        = 8'h10;
    y        = 8'h20;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out",   32'(out),       32'd0);
    check("mid_rst_carry", 32'(carry),     32'd0);
    check("mid_rst_zero",  32'(zero),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready_high", 32'(in_ready), 32'd1);
    run_op('{"post_rst_add", 4'b0000, 8'h12, 8'h34, 8'h46, 1'b0, 1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
